uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter OVERSAMPLE, default 16, sample ticks per bit period; SHALL be an even value of at least 4.
REQ-002 system_clock  input  1  single clock for all sequential logic.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 clock_enable  input  1  oversample tick, one system_clock cycle wide, OVERSAMPLE ticks per bit.
REQ-005 rx  input  1  asynchronous serial line, idle high.
REQ-006 data_ack  input  1  consumer has taken data_out.
REQ-007 data_out  output  8  last accepted byte, LSB received first.
REQ-008 data_valid  output  1  data_out holds an unacknowledged byte.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 framing_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 overrun  output  1  one-cycle pulse when a completed byte is dropped.
REQ-012 byte_counter  output  17  count of bytes accepted into data_out.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use; the synchronized value is rx_s.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, STOP, and WAIT_HIGH; state, tick counter and bit counter SHALL advance only on cycles with clock_enable=1.
REQ-015 IDLE: rx_s=0 on a tick -> START, with tick counter cleared.
REQ-016 START: at tick OVERSAMPLE/2-1, sample rx_s; 0 -> DATA with counters cleared; 1 (glitch) -> IDLE, with no output activity.
REQ-017 DATA: sample rx_s every OVERSAMPLE ticks after the start-bit midpoint; shift into an internal register LSB-first; after 8 samples -> STOP.
REQ-018 STOP: sample rx_s one bit period after the last data sample; 1 -> deliver the byte and go to IDLE; 0 -> pulse framing_error, discard the byte, go to WAIT_HIGH.
REQ-019 WAIT_HIGH: rx_s=1 on a tick -> IDLE.
REQ-020 Delivery when data_valid=0, or when data_valid=1 and data_ack=1 in the same cycle: load data_out, set data_valid=1, increment byte_counter.
REQ-021 Delivery when data_valid=1 and data_ack=0: drop the new byte, keep data_out and data_valid unchanged, pulse overrun, leave byte_counter unchanged.
REQ-022 data_ack=1 with data_valid=1 and no delivery in the same cycle: data_valid=0 on the next cycle; data_ack with data_valid=0 SHALL be ignored.
REQ-023 Delivery latency: data_valid SHALL rise on the cycle after the stop-bit sample tick.
REQ-024 byte_counter SHALL wrap from 17'h1FFFF to 0.
REQ-025 busy SHALL be combinational from the state register; framing_error and overrun SHALL be registered.
REQ-026 clock_enable=0 SHALL freeze the FSM and counters; the synchronizer and the data_ack handling SHALL continue to run every cycle.

Reset
REQ-027 With rst_n=0, asynchronously: state=IDLE, counters=0, synchronizer flops=1, data_out=0, data_valid=0, busy=0, framing_error=0, overrun=0, byte_counter=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no delivery; after release, the receiver SHALL wait for a new falling edge.
REQ-029 A low rx at reset release SHALL be treated as a start edge on the first tick.

Verification
REQ-030 Byte 0xA5 at 16 ticks/bit with a valid stop bit -> data_out=0xA5, data_valid=1 one cycle after the stop sample, byte_counter=1, framing_error=0.
REQ-031 Low pulse on rx lasting 5 ticks -> return to IDLE from START, data_valid=0, byte_counter=0.
REQ-032 Byte 0x3C with the stop bit low -> framing_error pulses for 1 cycle, data_valid=0; line held low 40 ticks then high -> IDLE; the next 0x55 is received correctly.
REQ-033 Bytes 0x11 then 0x22 with no data_ack -> data_out=0x11, overrun pulse at the 0x22 stop, byte_counter=1; data_ack in the cycle of the 0x22 delivery instead -> data_out=0x22, no overrun, byte_counter=2.
REQ-034 rst_n pulsed low during data bit 4 of 0xFF -> all outputs 0, data_valid=0; the following 0x81 is received with byte_counter=1.
REQ-035 byte_counter preloaded by force to 17'h1FFFF, then one good byte received -> byte_counter=0.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled 8N1 receiver with start-glitch rejection, framing/overrun flags and a byte counter
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        system_clock,
  input  logic        rst_n,
  input  logic        clock_enable,
  input  logic        rx,
  input  logic        data_ack,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        framing_error,
  output logic        overrun,
  output logic [16:0] byte_counter
);
  localparam int TW = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;
  state_t r_state, w_next;
  logic r_sync1, r_sync2, w_rx_s;
  logic [TW-1:0] r_tick;
  logic [2:0] r_bit;
  logic [7:0] r_shift, r_data;
  logic r_valid, r_fe, r_ovr;
  logic [16:0] r_byte_counter;
  logic w_half, w_full, w_wrap, w_stop_sample, w_deliver;
  assign w_rx_s = r_sync2;
  assign w_half = r_tick == TW'(OVERSAMPLE / 2 - 1);
  assign w_full = r_tick == TW'(OVERSAMPLE - 1);
  assign w_wrap = (r_state == S_START) ? w_half : w_full;
  assign w_stop_sample = clock_enable && r_state == S_STOP && w_full;
  assign w_deliver = w_stop_sample && w_rx_s;
  assign data_out = r_data;
  assign data_valid = r_valid;
  assign framing_error = r_fe;
  assign overrun = r_ovr;
  assign byte_counter = r_byte_counter;
  // two-flop synchronizer on the serial line, idling high
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end
  // state register
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // next-state decode, only moves on oversample ticks
  always_comb begin
    w_next = r_state;
    if (clock_enable)
      case (r_state)
        S_IDLE:      if (!w_rx_s) w_next = S_START;
        S_START:     if (w_half) w_next = w_rx_s ? S_IDLE : S_DATA;
        S_DATA:      if (w_full && r_bit == 3'd7) w_next = S_STOP;
        S_STOP:      if (w_full) w_next = w_rx_s ? S_IDLE : S_WAIT_HIGH;
        S_WAIT_HIGH: if (w_rx_s) w_next = S_IDLE;
        default:     w_next = S_IDLE;
      endcase
  end
  // busy is a pure decode of the state register
  always_comb busy = r_state != S_IDLE;
  // tick/bit counters and LSB-first shift register, frozen between ticks
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
      r_bit <= '0;
      r_shift <= '0;
    end else if (clock_enable) begin
      r_tick <= (r_state == S_IDLE || r_state == S_WAIT_HIGH || w_wrap) ? '0 : r_tick + 1'b1;
      if (r_state == S_START) r_bit <= '0;
      else if (r_state == S_DATA && w_full) r_bit <= r_bit + 1'b1;
      if (r_state == S_DATA && w_full) r_shift <= {w_rx_s, r_shift[7:1]};
    end
  end
  // delivery handshake, error pulses and accepted-byte count run every cycle
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_valid <= 1'b0;
      r_fe <= 1'b0;
      r_ovr <= 1'b0;
      r_byte_counter <= '0;
    end else begin
      r_fe <= w_stop_sample && !w_rx_s;
      r_ovr <= w_deliver && r_valid && !data_ack;
      if (w_deliver && (!r_valid || data_ack)) begin
        r_data <= r_shift;
        r_valid <= 1'b1;
        r_byte_counter <= r_byte_counter + 1'b1;
      end else if (!w_deliver && data_ack) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: frame-level model of the receiver checked against the DUT every cycle, plus directed literal checks
module tb_uart_receiver;
  localparam int OS = 16;
  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, rx = 1'b1, data_ack = 1'b0;
  logic [7:0] data_out;
  logic data_valid, busy, framing_error, overrun;
  logic [16:0] byte_counter;
  int n_chk = 0, n_err = 0, n_fe = 0, n_ovr = 0, ack_mode = 0;
  logic s1 = 1'b1, s2 = 1'b1, m_rxs = 1'b1, m_dv = 1'b0, m_busy = 1'b0, m_fe = 1'b0, m_ovr = 1'b0, m_stop = 1'b0;
  logic a_ack = 1'b0, a_dv = 1'b0;
  logic [7:0] m_do = 8'h00;
  logic [16:0] m_cnt = 17'h0, cnt_off = 17'h0, m_exp_cnt;
  int m_left = 0;

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .system_clock(clk), .rst_n(rst_n), .clock_enable(ce), .rx(rx), .data_ack(data_ack),
    .data_out(data_out), .data_valid(data_valid), .busy(busy),
    .framing_error(framing_error), .overrun(overrun), .byte_counter(byte_counter)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : ce_gen
    int gap;
    gap = 2;
    forever begin
      @(posedge clk);
      #1;
      if (gap > 0) begin
        ce = 1'b0;
        gap--;
      end else begin
        ce = 1'b1;
        gap = ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(1, 3));
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    data_ack = (ack_mode == 3) || (ack_mode == 1 && $urandom_range(0, 7) == 0) ||
               (ack_mode == 2 && m_stop && m_left == 1 && ce);
  end

  task automatic step(output logic rs, output logic tk);
    @(posedge clk);
    m_fe = 1'b0;
    m_ovr = 1'b0;
    rs = 1'b0;
    tk = 1'b0;
    if (!rst_n) begin
      s1 = 1'b1; s2 = 1'b1; m_rxs = 1'b1; m_dv = 1'b0; m_busy = 1'b0;
      m_do = 8'h00; m_cnt = 17'h0; m_left = 0; m_stop = 1'b0; rs = 1'b1;
    end else begin
      m_rxs = s2;
      s2 = s1;
      s1 = rx;
      tk = ce;
      a_ack = data_ack;
      a_dv = m_dv;
      if (data_ack && m_dv) m_dv = 1'b0;
    end
  endtask

  task automatic wait_ticks(input int n, output logic rs);
    logic tk;
    m_left = n;
    rs = 1'b0;
    while (m_left > 0) begin
      step(rs, tk);
      if (rs) return;
      if (tk) m_left--;
    end
  endtask

  initial begin : model
    logic rs, tk;
    logic [7:0] sh;
    sh = 8'h00;
    forever begin
      step(rs, tk);
      if (!rs && tk && !m_rxs) begin
        m_busy = 1'b1;
        wait_ticks(OS / 2, rs);
        if (!rs && m_rxs) m_busy = 1'b0;
        else if (!rs) begin
          for (int k = 0; k < 8 && !rs; k++) begin
            wait_ticks(OS, rs);
            sh = {m_rxs, sh[7:1]};
          end
          if (!rs) begin
            m_stop = 1'b1;
            wait_ticks(OS, rs);
            m_stop = 1'b0;
            if (!rs && m_rxs) begin
              m_busy = 1'b0;
              if (!a_dv || a_ack) begin
                m_do = sh;
                m_dv = 1'b1;
                m_cnt = m_cnt + 17'd1;
              end else m_ovr = 1'b1;
            end else if (!rs) begin
              m_fe = 1'b1;
              do step(rs, tk); while (!rs && !(tk && m_rxs));
              m_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_data_valid", data_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_byte_counter", byte_counter, 0);
      chk("rst_busy", busy, 0);
      chk("rst_framing_error", framing_error, 0);
      chk("rst_overrun", overrun, 0);
    end else begin
      m_exp_cnt = m_cnt + cnt_off;
      chk("data_valid", data_valid, m_dv);
      chk("data_out", data_out, m_do);
      chk("byte_counter", byte_counter, m_exp_cnt);
      chk("busy", busy, m_busy);
      chk("framing_error", framing_error, m_fe);
      chk("overrun", overrun, m_ovr);
    end
    if (framing_error) n_fe++;
    if (overrun) n_ovr++;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 90000 cycles, errors so far %0d", n_err);
    $fatal(1, "timeout");
  end

  task automatic wait_tick;
    do @(posedge clk); while (!ce);
    #3;
  endtask

  task automatic hold(input logic lvl, input int n);
    rx = lvl;
    repeat (n) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    hold(1'b0, OS);
    for (int i = 0; i < 8; i++) hold(b[i], OS);
    hold(stop, OS);
    rx = 1'b1;
  endtask

  task automatic settle;
    @(posedge clk);
    #4;
  endtask

  task automatic ack_pulse;
    @(posedge clk);
    #1;
    ack_mode = 3;
    @(posedge clk);
    #1;
    ack_mode = 0;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    cnt_off = 17'h0;
    settle();
    chk("in_reset_data_out", data_out, 0);
    chk("in_reset_data_valid", data_valid, 0);
    chk("in_reset_byte_counter", byte_counter, 0);
    chk("in_reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #4;
    chk("reset_data_valid", data_valid, 0);
    chk("reset_byte_counter", byte_counter, 0);
    rst_n = 1'b1;
    hold(1'b1, 4);
    hold(1'b0, 5);
    hold(1'b1, OS);
    settle();
    chk("glitch_data_valid", data_valid, 0);
    chk("glitch_byte_counter", byte_counter, 0);
    chk("glitch_busy", busy, 0);
    send_frame(8'hA5, 1'b1);
    hold(1'b1, 2);
    settle();
    chk("a5_data_out", data_out, 8'hA5);
    chk("a5_model_data_out", m_do, 8'hA5);
    chk("a5_data_valid", data_valid, 1);
    chk("a5_byte_counter", byte_counter, 1);
    chk("a5_fe_pulses", n_fe, 0);
    ack_pulse();
    settle();
    chk("ack_clears_valid", data_valid, 0);
    send_frame(8'h3C, 1'b0);
    hold(1'b0, 40);
    hold(1'b1, OS);
    settle();
    chk("3c_fe_pulses", n_fe, 1);
    chk("3c_data_valid", data_valid, 0);
    chk("3c_busy", busy, 0);
    chk("3c_byte_counter", byte_counter, 1);
    send_frame(8'h55, 1'b1);
    hold(1'b1, 2);
    settle();
    chk("55_data_out", data_out, 8'h55);
    chk("55_byte_counter", byte_counter, 2);
    ack_pulse();
    send_frame(8'h11, 1'b1);
    hold(1'b1, 2);
    send_frame(8'h22, 1'b1);
    hold(1'b1, 2);
    settle();
    chk("ovr_data_out", data_out, 8'h11);
    chk("ovr_pulses", n_ovr, 1);
    chk("ovr_byte_counter", byte_counter, 3);
    chk("ovr_model_counter", m_cnt, 3);
    ack_pulse();
    send_frame(8'h11, 1'b1);
    hold(1'b1, 2);
    ack_mode = 2;
    send_frame(8'h22, 1'b1);
    ack_mode = 0;
    hold(1'b1, 2);
    settle();
    chk("ack_same_cycle_data_out", data_out, 8'h22);
    chk("ack_same_cycle_ovr_pulses", n_ovr, 1);
    chk("ack_same_cycle_byte_counter", byte_counter, 5);
    chk("ack_same_cycle_valid", data_valid, 1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (OS + 4 * OS + OS / 2) wait_tick();
        pulse_reset();
      end
    join
    hold(1'b1, OS);
    settle();
    chk("abort_data_valid", data_valid, 0);
    chk("abort_data_out", data_out, 0);
    chk("abort_byte_counter", byte_counter, 0);
    chk("abort_busy", busy, 0);
    send_frame(8'h81, 1'b1);
    hold(1'b1, 2);
    settle();
    chk("81_data_out", data_out, 8'h81);
    chk("81_byte_counter", byte_counter, 1);
    rx = 1'b0;
    pulse_reset();
    send_frame(8'h5A, 1'b1);
    hold(1'b1, 2);
    settle();
    chk("low_at_release_data_out", data_out, 8'h5A);
    chk("low_at_release_byte_counter", byte_counter, 1);
    ack_pulse();
    @(posedge clk);
    #1;
    force dut.r_byte_counter = 17'h1FFFF;
    cnt_off = 17'h1FFFF - m_cnt;
    @(posedge clk);
    #1;
    release dut.r_byte_counter;
    send_frame(8'hC3, 1'b1);
    hold(1'b1, 2);
    settle();
    chk("wrap_byte_counter", byte_counter, 0);
    chk("wrap_data_out", data_out, 8'hC3);
    ack_pulse();
    ack_mode = 1;
    repeat (20) begin
      if ($urandom_range(0, 5) == 0) begin
        hold(1'b0, int'($urandom_range(1, OS / 2 - 2)));
        hold(1'b1, OS);
      end else begin
        send_frame(8'($urandom), $urandom_range(0, 7) != 0);
        hold(1'b1, int'($urandom_range(1, OS)));
      end
    end
    ack_mode = 0;
    hold(1'b1, OS);
    settle();
    chk("final_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
